onchip_mem_arbiter: RTL and testbench

ONCHIP_MEM_ARBITER -- requirements
Module: onchip_mem_arbiter

---
 rtl/onchip_mem_arbiter_if.sv | 26 ++
 rtl/onchip_mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_onchip_mem_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/onchip_mem_arbiter_if.sv
// Requester-side bus bundle for onchip_mem_arbiter.
// The master modport is the requester's view; the slave modport is the arbiter's view.
interface onchip_mem_arbiter_if;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [BE_W-1:0]   byteenable;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// Two-requester arbiter for a single-port on-chip memory with a bounded hold per owner.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin arbitration; default is fixed priority to m0.
module onchip_mem_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    onchip_mem_arbiter_if.slave  m0,
    onchip_mem_arbiter_if.slave  m1,
    output logic [11:0]          mem_address,
    output logic                 mem_chipselect,
    output logic                 mem_write,
    output logic [31:0]          mem_writedata,
    output logic [3:0]           mem_byteenable,
    output logic                 mem_clken,
    input  logic [31:0]          mem_readdata
);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             rdv0_q, rdv0_d;
    logic             rdv1_q, rdv1_d;

    logic req0, req1;
    logic own_m1, owned, req_own, acc, release_own, arb_go, arb_m1;
    logic wait0, wait1;

    assign req0 = m0.read | m0.write;
    assign req1 = m1.read | m1.write;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;

    // Contested grants alternate away from the most recent winner.
    assign arb_m1       = (req0 & req1) ? ~last_grant_q : req1;
    assign last_grant_d = arb_go ? arb_m1 : last_grant_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    assign arb_m1 = req1 & ~req0;
`endif

    // State, hold counter and read-return tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            rdv0_q  <= 1'b0;
            rdv1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            rdv0_q  <= rdv0_d;
            rdv1_q  <= rdv1_d;
        end
    end

    // Ownership view shared by both owned states.
    always_comb begin
        owned       = 1'b0;
        own_m1      = 1'b0;
        req_own     = 1'b0;
        acc         = 1'b0;
        release_own = 1'b0;
        arb_go      = 1'b0;
        if (state_q == OWN0 || state_q == OWN1) begin
            owned       = 1'b1;
            own_m1      = (state_q == OWN1);
            req_own     = own_m1 ? req1 : req0;
            acc         = req_own;
            release_own = ~req_own | (hold_q == HOLD_LAST);
        end
        arb_go = ((state_q == IDLE) | release_own) & (req0 | req1);
    end

    // Next state, hold counter and combinational bus outputs.
    always_comb begin
        state_d        = state_q;
        hold_d         = hold_q;
        rdv0_d         = 1'b0;
        rdv1_d         = 1'b0;
        wait0          = 1'b1;
        wait1          = 1'b1;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_writedata  = '0;
        mem_byteenable = '0;

        case (state_q)
            IDLE: begin
                if (arb_go) begin
                    state_d = arb_m1 ? OWN1 : OWN0;
                    hold_d  = '0;
                end
            end
            OWN0, OWN1: begin
                if (own_m1) begin
                    wait1 = ~req1;
                end else begin
                    wait0 = ~req0;
                end
                if (acc) begin
                    mem_chipselect = 1'b1;
                    mem_write      = own_m1 ? m1.write      : m0.write;
                    mem_address    = own_m1 ? m1.address    : m0.address;
                    mem_writedata  = own_m1 ? m1.writedata  : m0.writedata;
                    mem_byteenable = own_m1 ? m1.byteenable : m0.byteenable;
                    // Read with write also high is a write: no data is returned.
                    rdv0_d = ~own_m1 & m0.read & ~m0.write;
                    rdv1_d =  own_m1 & m1.read & ~m1.write;
                end
                if (arb_go) begin
                    state_d = arb_m1 ? OWN1 : OWN0;
                    hold_d  = '0;
                end else if (release_own) begin
                    state_d = IDLE;
                    hold_d  = '0;
                end else if (acc) begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase
    end

    assign m0.waitrequest   = wait0;
    assign m1.waitrequest   = wait1;
    assign m0.readdata      = mem_readdata;
    assign m1.readdata      = mem_readdata;
    assign m0.readdatavalid = rdv0_q;
    assign m1.readdatavalid = rdv1_q;
    assign mem_clken        = reset_n;

    logic unused_owned;
    assign unused_owned = owned;
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed self-checking bench for onchip_mem_arbiter with a behavioural one-cycle-latency RAM.
module tb_onchip_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [11:0] mem_address;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteenable;
    logic        mem_clken;
    logic [31:0] mem_readdata;

    int checks = 0;
    int errors = 0;

    onchip_mem_arbiter_if m0_if ();
    onchip_mem_arbiter_if m1_if ();

    onchip_mem_arbiter #(.MAX_HOLD(4)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .m0             (m0_if),
        .m1             (m1_if),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_byteenable (mem_byteenable),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata)
    );

    always #5 clk = ~clk;

    // Byte-enabled RAM, read data one cycle after the address is clocked.
    logic [31:0] ram [4096];
    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end
            mem_readdata <= ram[mem_address];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int n, input logic rd, input logic wr, input logic [11:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        if (n == 0) begin
            m0_if.read = rd; m0_if.write = wr; m0_if.address = a; m0_if.writedata = d; m0_if.byteenable = be;
        end else begin
            m1_if.read = rd; m1_if.write = wr; m1_if.address = a; m1_if.writedata = d; m1_if.byteenable = be;
        end
    endtask

    task automatic go_idle;
        drive(0, 1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
        repeat (3) tick;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        drive(0, 1'b0, 1'b1, 12'h055, 32'h12345678, 4'hF);
        drive(1, 1'b1, 1'b0, 12'h066, 32'h0, 4'hF);
        repeat (2) tick;
        #1;
        checks++; if (m0_if.waitrequest !== 1'b1) begin errors++; $display("FAIL rst_wait0 got %b want 1", m0_if.waitrequest); end
        checks++; if (m1_if.waitrequest !== 1'b1) begin errors++; $display("FAIL rst_wait1 got %b want 1", m1_if.waitrequest); end
        checks++; if (m0_if.readdatavalid !== 1'b0) begin errors++; $display("FAIL rst_rdv0 got %b want 0", m0_if.readdatavalid); end
        checks++; if (m1_if.readdatavalid !== 1'b0) begin errors++; $display("FAIL rst_rdv1 got %b want 0", m1_if.readdatavalid); end
        checks++; if (mem_chipselect !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL rst_cs_we got %b%b want 00", mem_chipselect, mem_write); end
        checks++; if (mem_address !== 12'h0 || mem_writedata !== 32'h0 || mem_byteenable !== 4'h0) begin errors++; $display("FAIL rst_bus got %h/%h/%h want 0/0/0", mem_address, mem_writedata, mem_byteenable); end
        checks++; if (mem_clken !== 1'b0) begin errors++; $display("FAIL rst_clken got %b want 0", mem_clken); end
        tick;
        reset_n = 1'b1;
        go_idle();
        checks++; if (mem_clken !== 1'b1) begin errors++; $display("FAIL run_clken got %b want 1", mem_clken); end
    endtask

    task automatic test_write_read;
        drive(0, 1'b0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF);
        #1;
        checks++; if (m0_if.waitrequest !== 1'b1 || mem_chipselect !== 1'b0) begin errors++; $display("FAIL wr_idle got wait=%b cs=%b want 1 0", m0_if.waitrequest, mem_chipselect); end
        tick;
        #1;
        checks++; if (m0_if.waitrequest !== 1'b0 || mem_chipselect !== 1'b1 || mem_write !== 1'b1) begin errors++; $display("FAIL wr_accept got wait=%b cs=%b we=%b want 0 1 1", m0_if.waitrequest, mem_chipselect, mem_write); end
        checks++; if (mem_address !== 12'h010 || mem_writedata !== 32'hDEADBEEF || mem_byteenable !== 4'hF) begin errors++; $display("FAIL wr_bus got %h/%h/%h want 010/deadbeef/f", mem_address, mem_writedata, mem_byteenable); end
        checks++; if (m1_if.waitrequest !== 1'b1) begin errors++; $display("FAIL wr_wait1 got %b want 1", m1_if.waitrequest); end
        tick;
        drive(0, 1'b1, 1'b0, 12'h010, 32'h0, 4'hF);
        #1;
        checks++; if (m0_if.waitrequest !== 1'b0 || mem_write !== 1'b0 || m0_if.readdatavalid !== 1'b0) begin errors++; $display("FAIL rd_accept got wait=%b we=%b rdv=%b want 0 0 0", m0_if.waitrequest, mem_write, m0_if.readdatavalid); end
        tick;
        drive(0, 1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
        #1;
        checks++; if (m0_if.readdatavalid !== 1'b1 || m1_if.readdatavalid !== 1'b0) begin errors++; $display("FAIL rd_rdv got %b%b want 10", m0_if.readdatavalid, m1_if.readdatavalid); end
        checks++; if (m0_if.readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h want deadbeef", m0_if.readdata); end
        tick;
        #1;
        checks++; if (m0_if.readdatavalid !== 1'b0) begin errors++; $display("FAIL rd_rdv_pulse got %b want 0", m0_if.readdatavalid); end
        go_idle();
    endtask

    task automatic test_back_to_back;
        int owner;
        logic exp_w0, exp_w1;
        drive(0, 1'b0, 1'b1, 12'h100, 32'hA0A0A0A0, 4'hF);
        drive(1, 1'b0, 1'b1, 12'h200, 32'hB1B1B1B1, 4'hF);
        for (int c = 0; c < 13; c++) begin
            #1;
`ifdef ARB_ROUND_ROBIN_EN
            owner = (c == 0) ? -1 : (((c - 1) / 4) % 2);
`else
            owner = (c == 0) ? -1 : 0;
`endif
            exp_w0 = (owner != 0);
            exp_w1 = (owner != 1);
            checks++; if (m0_if.waitrequest !== exp_w0) begin errors++; $display("FAIL b2b_wait0 c=%0d got %b want %b", c, m0_if.waitrequest, exp_w0); end
            checks++; if (m1_if.waitrequest !== exp_w1) begin errors++; $display("FAIL b2b_wait1 c=%0d got %b want %b", c, m1_if.waitrequest, exp_w1); end
            checks++; if (mem_chipselect !== (owner >= 0)) begin errors++; $display("FAIL b2b_cs c=%0d got %b want %b", c, mem_chipselect, owner >= 0); end
            tick;
        end
        go_idle();
    endtask

    task automatic test_handover;
        drive(1, 1'b0, 1'b1, 12'h7FF, 32'hCAFE0001, 4'hF);
        #1;
        checks++; if (m1_if.waitrequest !== 1'b1) begin errors++; $display("FAIL ho_idle got %b want 1", m1_if.waitrequest); end
        tick;
        drive(0, 1'b1, 1'b0, 12'h020, 32'h0, 4'hF);
        #1;
        checks++; if (m1_if.waitrequest !== 1'b0 || m0_if.waitrequest !== 1'b1 || mem_address !== 12'h7FF) begin errors++; $display("FAIL ho_own1 got w1=%b w0=%b a=%h want 0 1 7ff", m1_if.waitrequest, m0_if.waitrequest, mem_address); end
        tick;
        drive(1, 1'b0, 1'b1, 12'h7FF, 32'hCAFE0002, 4'hF);
        tick;
        drive(1, 1'b0, 1'b1, 12'h7FF, 32'hCAFE0003, 4'hF);
        tick;
        drive(1, 1'b1, 1'b0, 12'h7FF, 32'h0, 4'hF);
        #1;
        checks++; if (m1_if.waitrequest !== 1'b0 || mem_write !== 1'b0 || m0_if.waitrequest !== 1'b1) begin errors++; $display("FAIL ho_rd got w1=%b we=%b w0=%b want 0 0 1", m1_if.waitrequest, mem_write, m0_if.waitrequest); end
        tick;
        drive(1, 1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
        #1;
        checks++; if (m1_if.readdatavalid !== 1'b1 || m0_if.readdatavalid !== 1'b0) begin errors++; $display("FAIL ho_rdv got m1=%b m0=%b want 1 0", m1_if.readdatavalid, m0_if.readdatavalid); end
        checks++; if (m1_if.readdata !== 32'hCAFE0003) begin errors++; $display("FAIL ho_data got %h want cafe0003", m1_if.readdata); end
        checks++; if (m0_if.waitrequest !== 1'b0 || mem_address !== 12'h020) begin errors++; $display("FAIL ho_own0 got w0=%b a=%h want 0 020", m0_if.waitrequest, mem_address); end
        tick;
        drive(0, 1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
        #1;
        checks++; if (m0_if.readdatavalid !== 1'b1 || m1_if.readdatavalid !== 1'b0) begin errors++; $display("FAIL ho_rdv0 got m0=%b m1=%b want 1 0", m0_if.readdatavalid, m1_if.readdatavalid); end
        go_idle();
    endtask

    task automatic test_byteenable;
        drive(0, 1'b0, 1'b1, 12'h030, 32'hFFFFFFFF, 4'hF);
        tick;
        tick;
        drive(0, 1'b1, 1'b1, 12'h030, 32'h11223344, 4'h3);
        #1;
        checks++; if (mem_write !== 1'b1 || mem_byteenable !== 4'h3) begin errors++; $display("FAIL be_write got we=%b be=%h want 1 3", mem_write, mem_byteenable); end
        tick;
        drive(0, 1'b1, 1'b0, 12'h030, 32'h0, 4'hF);
        #1;
        checks++; if (m0_if.readdatavalid !== 1'b0) begin errors++; $display("FAIL rw_no_rdv got %b want 0", m0_if.readdatavalid); end
        tick;
        drive(0, 1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
        #1;
        checks++; if (m0_if.readdatavalid !== 1'b1 || m0_if.readdata !== 32'hFFFF3344) begin errors++; $display("FAIL be_readback got rdv=%b d=%h want 1 ffff3344", m0_if.readdatavalid, m0_if.readdata); end
        go_idle();
    endtask

    task automatic test_reset_mid_access;
        drive(0, 1'b1, 1'b0, 12'h010, 32'h0, 4'hF);
        tick;
        #1;
        checks++; if (mem_chipselect !== 1'b1) begin errors++; $display("FAIL rm_cs got %b want 1", mem_chipselect); end
        tick;
        reset_n = 1'b0;
        drive(0, 1'b0, 1'b1, 12'h010, 32'h00000000, 4'hF);
        #1;
        checks++; if (m0_if.readdatavalid !== 1'b0) begin errors++; $display("FAIL rm_rdv got %b want 0", m0_if.readdatavalid); end
        checks++; if (m0_if.waitrequest !== 1'b1 || mem_chipselect !== 1'b0 || mem_write !== 1'b0 || mem_clken !== 1'b0) begin errors++; $display("FAIL rm_outs got w=%b cs=%b we=%b ck=%b want 1 0 0 0", m0_if.waitrequest, mem_chipselect, mem_write, mem_clken); end
        tick;
        #1;
        checks++; if (m0_if.readdatavalid !== 1'b0 || mem_address !== 12'h0) begin errors++; $display("FAIL rm_hold got rdv=%b a=%h want 0 000", m0_if.readdatavalid, mem_address); end
        tick;
        reset_n = 1'b1;
        drive(0, 1'b1, 1'b0, 12'h010, 32'h0, 4'hF);
        #1;
        checks++; if (m0_if.waitrequest !== 1'b1) begin errors++; $display("FAIL rm_idle got %b want 1", m0_if.waitrequest); end
        tick;
        #1;
        checks++; if (m0_if.waitrequest !== 1'b0 || mem_chipselect !== 1'b1 || mem_address !== 12'h010) begin errors++; $display("FAIL rm_serve got w=%b cs=%b a=%h want 0 1 010", m0_if.waitrequest, mem_chipselect, mem_address); end
        tick;
        drive(0, 1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
        #1;
        checks++; if (m0_if.readdatavalid !== 1'b1 || m0_if.readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rm_data got rdv=%b d=%h want 1 deadbeef", m0_if.readdatavalid, m0_if.readdata); end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_handover();
        test_byteenable();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
